// File: rtl/apb_gcd_queue_pkg.sv
// Shared register map, control/status/interrupt bit positions and engine state encoding.
// Latency: none, declarations only.
// Backpressure: not applicable.
package gcd_apb_pkg;

    // Byte offsets of the 32-bit registers
    localparam logic [7:0] REG_CTRL      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_DATA_IN   = 8'h08;
    localparam logic [7:0] REG_DATA_OUT  = 8'h0C;
    localparam logic [7:0] REG_INTR_STAT = 8'h10;

    // CTRL bits
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE_DONE = 1;
    localparam int CTRL_IE_OVF  = 2;
    localparam int CTRL_IE_UNF  = 3;
    localparam int CTRL_FLUSH   = 4;

    // STATUS bits
    localparam int ST_CMD_FULL  = 0;
    localparam int ST_CMD_EMPTY = 1;
    localparam int ST_RES_FULL  = 2;
    localparam int ST_RES_EMPTY = 3;
    localparam int ST_BUSY      = 4;

    // INTR_STAT bits
    localparam int INTR_DONE = 0;
    localparam int INTR_OVF  = 1;
    localparam int INTR_UNF  = 2;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_CALC = 2'd1,
        ENG_DONE = 2'd2
    } eng_state_e;

endpackage

// File: rtl/apb_gcd_queue_if.sv
// APB slave bus bundle for the GCD queue; master drives request, slave returns response.
// Latency: none, wires only.
// Backpressure: o_pready carries the slave's wait-state request.
interface apb_gcd_queue_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              i_psel;
    logic              i_penable;
    logic              i_pwrite;
    logic [ADDR_W-1:0] i_paddr;
    logic [DATA_W-1:0] i_pwdata;
    logic [DATA_W-1:0] o_prdata;
    logic              o_pready;
    logic              o_pslverr;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  o_prdata, o_pready, o_pslverr
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output o_prdata, o_pready, o_pslverr
    );
endinterface

// File: rtl/apb_gcd_queue_engine.sv
// Subtractive GCD engine: takes one {a,b} command, iterates one subtraction per cycle, offers the result.
// Latency: 1 cycle load, 1 cycle per CALC step (including the final compare), then at least 1 cycle in DONE.
// Backpressure: accepts a command only when idle and enabled; holds in DONE until res_rdy_i.
module gcd_engine
    import gcd_apb_pkg::*;
#(
    parameter int OPW = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             cmd_vld_i,
    output logic             cmd_rdy_o,
    input  logic [2*OPW-1:0] cmd_dat_i,
    output logic             res_vld_o,
    input  logic             res_rdy_i,
    output logic [OPW-1:0]   res_dat_o,
    output logic             busy_o
);

    eng_state_e     state_q, state_d;
    logic [OPW-1:0] a_q, a_d, b_q, b_d;

    // State and operand registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ENG_IDLE;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next state: flush beats everything, otherwise load / subtract / hand off
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        if (flush_i) begin
            state_d = ENG_IDLE;
            a_d     = '0;
            b_d     = '0;
        end else begin
            case (state_q)
                ENG_IDLE: begin
                    if (en_i && cmd_vld_i) begin
                        state_d = ENG_CALC;
                        a_d     = cmd_dat_i[2*OPW-1:OPW];
                        b_d     = cmd_dat_i[OPW-1:0];
                    end
                end
                ENG_CALC: begin
                    if (a_q == '0 || b_q == '0 || a_q == b_q) begin
                        state_d = ENG_DONE;
                    end else if (a_q > b_q) begin
                        a_d = a_q - b_q;
                    end else begin
                        b_d = b_q - a_q;
                    end
                end
                ENG_DONE: begin
                    if (res_rdy_i) begin
                        state_d = ENG_IDLE;
                    end
                end
                default: state_d = ENG_IDLE;
            endcase
        end
    end

    // Handshake outputs; the result is a|b, which is the nonzero operand or the common value
    always_comb begin
        cmd_rdy_o = (state_q == ENG_IDLE) && en_i && !flush_i;
        res_vld_o = (state_q == ENG_DONE) && !flush_i;
        res_dat_o = a_q | b_q;
        busy_o    = (state_q != ENG_IDLE);
    end

endmodule

// File: rtl/apb_gcd_queue.sv
// APB-programmable GCD queue: command FIFO -> GCD engine -> result FIFO, with W1C interrupt status.
// Latency: zero-wait-state APB; a result lands after load + CALC steps + one DONE cycle.
// Backpressure: full command FIFO drops writes (OVF, pslverr); full result FIFO stalls the engine in DONE.
module apb_gcd_queue
    import gcd_apb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int OPW    = 16,
    parameter int DEPTH  = 4
) (
    input  logic           clk,
    input  logic           rstn,
    apb_gcd_queue_if.slave bus,
    output logic           o_intr
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    function automatic logic reg_hit(input logic [ADDR_W-3:0] waddr, input logic [7:0] off);
        logic [ADDR_W-1:0] off_ext;
        off_ext = ADDR_W'(off);
        return waddr == off_ext[ADDR_W-1:2];
    endfunction

    logic              acc, wr, rd, flush;
    logic              sel_ctrl, sel_stat, sel_din, sel_dout, sel_intr, mapped;
    logic [ADDR_W-3:0] waddr;
    logic [DATA_W-1:0] prdata;
    logic              unused_bits;

    logic [3:0] ctrl_q, ctrl_d;
    logic [2:0] intr_q, intr_d;
    logic       intr_o_q, intr_o_d;

    logic [2*OPW-1:0] cmd_mem_q [DEPTH];
    logic [OPW-1:0]   res_mem_q [DEPTH];
    logic [PW-1:0]    cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
    logic [PW-1:0]    res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [CW-1:0]    cmd_cnt_q, cmd_cnt_d, res_cnt_q, res_cnt_d;
    logic             cmd_full, cmd_empty, res_full, res_empty;
    logic             cmd_push, cmd_pop, res_push, res_pop;

    logic           eng_cmd_rdy, eng_res_vld, eng_busy;
    logic [OPW-1:0] eng_res_dat;

    assign acc       = bus.i_psel & bus.i_penable;
    assign wr        = acc & bus.i_pwrite;
    assign rd        = acc & ~bus.i_pwrite;
    assign waddr     = bus.i_paddr[ADDR_W-1:2];
    assign sel_ctrl  = reg_hit(waddr, REG_CTRL);
    assign sel_stat  = reg_hit(waddr, REG_STATUS);
    assign sel_din   = reg_hit(waddr, REG_DATA_IN);
    assign sel_dout  = reg_hit(waddr, REG_DATA_OUT);
    assign sel_intr  = reg_hit(waddr, REG_INTR_STAT);
    assign mapped    = sel_ctrl | sel_stat | sel_din | sel_dout | sel_intr;
    assign flush     = wr & sel_ctrl & bus.i_pwdata[CTRL_FLUSH];

    assign cmd_full  = (cmd_cnt_q == CW'(DEPTH));
    assign cmd_empty = (cmd_cnt_q == '0);
    assign res_full  = (res_cnt_q == CW'(DEPTH));
    assign res_empty = (res_cnt_q == '0);

    // FULL/EMPTY are the pre-edge values, so a same-cycle engine pop cannot rescue a write
    assign cmd_push  = wr & sel_din & ~cmd_full;
    assign cmd_pop   = eng_cmd_rdy & ~cmd_empty;
    assign res_push  = eng_res_vld & ~res_full;
    assign res_pop   = rd & sel_dout & ~res_empty;

    assign bus.o_pready  = 1'b1;
    assign bus.o_pslverr = acc & (~mapped | (bus.i_pwrite & (sel_stat | sel_dout))
                                 | (wr & sel_din & cmd_full) | (rd & sel_dout & res_empty));
    assign bus.o_prdata  = prdata;
    assign o_intr        = intr_o_q;
    assign unused_bits   = ^{bus.i_paddr[1:0], bus.i_pwdata};

    gcd_engine #(.OPW(OPW)) u_engine (
        .clk       (clk),
        .rstn      (rstn),
        .en_i      (ctrl_q[CTRL_EN]),
        .flush_i   (flush),
        .cmd_vld_i (~cmd_empty),
        .cmd_rdy_o (eng_cmd_rdy),
        .cmd_dat_i (cmd_mem_q[cmd_rp_q]),
        .res_vld_o (eng_res_vld),
        .res_rdy_i (~res_full),
        .res_dat_o (eng_res_dat),
        .busy_o    (eng_busy)
    );

    // Read mux: only live during read access cycles, zero elsewhere
    always_comb begin
        prdata = '0;
        if (rd) begin
            if (sel_ctrl) begin
                prdata[3:0] = ctrl_q;
            end else if (sel_stat) begin
                prdata[ST_CMD_FULL]  = cmd_full;
                prdata[ST_CMD_EMPTY] = cmd_empty;
                prdata[ST_RES_FULL]  = res_full;
                prdata[ST_RES_EMPTY] = res_empty;
                prdata[ST_BUSY]      = eng_busy;
                prdata[15:8]         = 8'(cmd_cnt_q);
                prdata[23:16]        = 8'(res_cnt_q);
            end else if (sel_dout && !res_empty) begin
                prdata[OPW-1:0] = res_mem_q[res_rp_q];
            end else if (sel_intr) begin
                prdata[2:0] = intr_q;
            end
        end
    end

    // Control, interrupt status (hardware set beats W1C) and registered interrupt line
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr && sel_ctrl) begin
            ctrl_d = bus.i_pwdata[3:0];
        end
        intr_d = intr_q;
        if (wr && sel_intr) begin
            intr_d = intr_q & ~bus.i_pwdata[2:0];
        end
        if (res_push)                       intr_d[INTR_DONE] = 1'b1;
        if (wr && sel_din && cmd_full)      intr_d[INTR_OVF]  = 1'b1;
        if (rd && sel_dout && res_empty)    intr_d[INTR_UNF]  = 1'b1;
        intr_o_d = |(intr_q & ctrl_q[CTRL_IE_UNF:CTRL_IE_DONE]);
    end

    // FIFO pointers and counts; flush clears both queues
    always_comb begin
        cmd_wp_d  = cmd_push ? cmd_wp_q + PW'(1) : cmd_wp_q;
        cmd_rp_d  = cmd_pop  ? cmd_rp_q + PW'(1) : cmd_rp_q;
        cmd_cnt_d = cmd_cnt_q + CW'(cmd_push) - CW'(cmd_pop);
        res_wp_d  = res_push ? res_wp_q + PW'(1) : res_wp_q;
        res_rp_d  = res_pop  ? res_rp_q + PW'(1) : res_rp_q;
        res_cnt_d = res_cnt_q + CW'(res_push) - CW'(res_pop);
        if (flush) begin
            cmd_wp_d  = '0;
            cmd_rp_d  = '0;
            cmd_cnt_d = '0;
            res_wp_d  = '0;
            res_rp_d  = '0;
            res_cnt_d = '0;
        end
    end

    // Register state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q    <= '0;
            intr_q    <= '0;
            intr_o_q  <= 1'b0;
            cmd_wp_q  <= '0;
            cmd_rp_q  <= '0;
            cmd_cnt_q <= '0;
            res_wp_q  <= '0;
            res_rp_q  <= '0;
            res_cnt_q <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            intr_q    <= intr_d;
            intr_o_q  <= intr_o_d;
            cmd_wp_q  <= cmd_wp_d;
            cmd_rp_q  <= cmd_rp_d;
            cmd_cnt_q <= cmd_cnt_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            res_cnt_q <= res_cnt_d;
        end
    end

    // FIFO storage needs no reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem_q[cmd_wp_q] <= {bus.i_pwdata[DATA_W/2+OPW-1:DATA_W/2], bus.i_pwdata[OPW-1:0]};
        if (res_push) res_mem_q[res_wp_q] <= eng_res_dat;
    end

endmodule

// File: tb/tb_apb_gcd_queue.sv
module tb_apb_gcd_queue;
    import gcd_apb_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic o_intr;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_q [$];

    apb_gcd_queue_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    apb_gcd_queue #(.ADDR_W(8), .DATA_W(32), .OPW(16), .DEPTH(4)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus    (bus.slave),
        .o_intr (o_intr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] gcd(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [31:0] stat(input int cmd, input int res, input logic busy);
        logic [31:0] s;
        s        = '0;
        s[0]     = (cmd == 4);
        s[1]     = (cmd == 0);
        s[2]     = (res == 4);
        s[3]     = (res == 0);
        s[4]     = busy;
        s[15:8]  = 8'(cmd);
        s[23:16] = 8'(res);
        return s;
    endfunction

    // One APB transfer; called at #1 after a rising edge, returns at #1 after the access edge
    task automatic apb_xfer(input logic w, input logic [7:0] addr, input logic [31:0] wd,
                            output logic [31:0] rdat, output logic err);
        bus.i_psel    = 1'b1;
        bus.i_penable = 1'b0;
        bus.i_pwrite  = w;
        bus.i_paddr   = addr;
        bus.i_pwdata  = wd;
        @(posedge clk); #1;
        bus.i_penable = 1'b1;
        #1;
        rdat = bus.o_prdata;
        err  = bus.o_pslverr;
        @(posedge clk); #1;
        bus.i_psel    = 1'b0;
        bus.i_penable = 1'b0;
        bus.i_pwrite  = 1'b0;
    endtask

    task automatic wr_reg(input logic [7:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b1, addr, wd, d, e);
    endtask

    task automatic rd_reg(input logic [7:0] addr, output logic [31:0] d);
        logic e;
        apb_xfer(1'b0, addr, 32'h0, d, e);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [15:0] a, input logic [15:0] b, input logic exp_err);
        logic [31:0] d;
        logic        e;
        apb_xfer(1'b1, REG_DATA_IN, {a, b}, d, e);
        check("din_pslverr", 32'(e), 32'(exp_err));
        if (!exp_err) exp_q.push_back(gcd(a, b));
    endtask

    task automatic read_res(input string tag);
        logic [31:0] d;
        logic        e;
        logic [15:0] x;
        apb_xfer(1'b0, REG_DATA_OUT, 32'h0, d, e);
        check({tag, "_pslverr"}, 32'(e), 32'h0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_depth"}, 32'(exp_q.size()), 32'h1);
        end else begin
            x = exp_q.pop_front();
            check(tag, d, {16'h0, x});
        end
    endtask

    task automatic wait_res(input int n, input string tag);
        logic [31:0] s;
        int          got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            rd_reg(REG_STATUS, s);
            got = int'(s[23:16]);
            if (got >= n) break;
        end
        check(tag, 32'(got >= n), 32'h1);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;

        bus.i_psel    = 1'b0;
        bus.i_penable = 1'b0;
        bus.i_pwrite  = 1'b0;
        bus.i_paddr   = '0;
        bus.i_pwdata  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_intr", 32'(o_intr), 32'h0);
        rstn = 1'b1;
        check("pready", 32'(bus.o_pready), 32'h1);
        rd_reg(REG_CTRL, r);       check("rst_ctrl", r, 32'h0);
        rd_reg(REG_STATUS, r);     check("rst_status", r, stat(0, 0, 1'b0));
        rd_reg(REG_INTR_STAT, r);  check("rst_intr_stat", r, 32'h0);
        apb_xfer(1'b0, 8'h40, 32'h0, r, e);
        check("unmapped_err", 32'(e), 32'h1);
        check("unmapped_data", r, 32'h0);

        // gcd(12,8) with DONE interrupt
        wr_reg(REG_CTRL, 32'h3);
        push_cmd(16'd12, 16'd8, 1'b0);
        rd_reg(REG_STATUS, r);     check("calc_busy", r, stat(0, 0, 1'b1));
        wait_res(1, "wait_12_8");
        read_res("res_12_8");
        rd_reg(REG_INTR_STAT, r);  check("done_set", r, 32'h1);
        check("intr_done", 32'(o_intr), 32'h1);
        wr_reg(REG_INTR_STAT, 32'h1);
        check("intr_lag", 32'(o_intr), 32'h1);
        idle(1);
        check("intr_fall", 32'(o_intr), 32'h0);
        apb_xfer(1'b1, REG_STATUS, 32'hFF, r, e);
        check("ro_write_err", 32'(e), 32'h1);

        // Zero operands, ordering
        push_cmd(16'd0, 16'd9, 1'b0);
        push_cmd(16'd0, 16'd0, 1'b0);
        wait_res(2, "wait_zero");
        read_res("res_0_9");
        read_res("res_0_0");

        // Overflow with engine disabled
        wr_reg(REG_CTRL, 32'h4);
        push_cmd(16'd48, 16'd18, 1'b0);
        push_cmd(16'd35, 16'd14, 1'b0);
        push_cmd(16'd17, 16'd5, 1'b0);
        push_cmd(16'd100, 16'd75, 1'b0);
        push_cmd(16'd9, 16'd3, 1'b1);
        rd_reg(REG_STATUS, r);     check("ovf_status", r, stat(4, 0, 1'b0));
        rd_reg(REG_INTR_STAT, r);  check("ovf_bit", 32'(r[1]), 32'h1);
        check("intr_ovf", 32'(o_intr), 32'h1);
        wr_reg(REG_CTRL, 32'h1);
        wait_res(4, "wait_ovf4");
        rd_reg(REG_STATUS, r);     check("four_results", r, stat(0, 4, 1'b0));
        for (int i = 0; i < 4; i++) read_res("res_ovf");

        // Underflow
        wr_reg(REG_CTRL, 32'h9);
        idle(2);
        check("intr_masked", 32'(o_intr), 32'h0);
        apb_xfer(1'b0, REG_DATA_OUT, 32'h0, r, e);
        check("unf_err", 32'(e), 32'h1);
        check("unf_data", r, 32'h0);
        rd_reg(REG_INTR_STAT, r);  check("unf_bit", 32'(r[2]), 32'h1);
        check("intr_unf", 32'(o_intr), 32'h1);
        wr_reg(REG_INTR_STAT, 32'h4);
        check("unf_lag", 32'(o_intr), 32'h1);
        idle(1);
        check("unf_fall", 32'(o_intr), 32'h0);
        rd_reg(REG_INTR_STAT, r);  check("unf_clear", 32'(r[2]), 32'h0);
        wr_reg(REG_INTR_STAT, 32'h7);

        // Result FIFO full holds the engine in DONE
        wr_reg(REG_CTRL, 32'h0);
        push_cmd(16'd6, 16'd4, 1'b0);
        push_cmd(16'd9, 16'd6, 1'b0);
        push_cmd(16'd10, 16'd4, 1'b0);
        push_cmd(16'd21, 16'd14, 1'b0);
        wr_reg(REG_CTRL, 32'h1);
        wait_res(4, "wait_fill");
        push_cmd(16'd15, 16'd10, 1'b0);
        push_cmd(16'd8, 16'd12, 1'b0);
        idle(20);
        rd_reg(REG_STATUS, r);     check("hold_status", r, stat(1, 4, 1'b1));
        read_res("res_hold");
        idle(20);
        rd_reg(REG_STATUS, r);     check("release_one", r, stat(0, 4, 1'b1));
        for (int i = 0; i < 5; i++) begin
            wait_res(1, "wait_drain");
            read_res("res_drain");
        end
        rd_reg(REG_STATUS, r);     check("drained", r, stat(0, 0, 1'b0));

        // FLUSH during a long CALC
        wr_reg(REG_INTR_STAT, 32'h7);
        push_cmd(16'd3, 16'd3, 1'b0);
        wait_res(1, "wait_3_3");
        push_cmd(16'd1000, 16'd1, 1'b0);
        idle(3);
        push_cmd(16'd7, 16'd7, 1'b0);
        rd_reg(REG_STATUS, r);     check("pre_flush", r, stat(1, 1, 1'b1));
        wr_reg(REG_CTRL, 32'h11);
        exp_q.delete();
        rd_reg(REG_STATUS, r);     check("post_flush", r, stat(0, 0, 1'b0));
        rd_reg(REG_CTRL, r);       check("flush_reads0", r, 32'h1);
        rd_reg(REG_INTR_STAT, r);  check("flush_keeps_intr", r, 32'h1);

        // Reset mid-CALC
        wr_reg(REG_CTRL, 32'h3);
        push_cmd(16'd1000, 16'd1, 1'b0);
        idle(5);
        rd_reg(REG_STATUS, r);     check("calc_long", r, stat(0, 0, 1'b1));
        check("intr_pre_rst", 32'(o_intr), 32'h1);
        rstn = 1'b0;
        #1;
        check("intr_in_rst", 32'(o_intr), 32'h0);
        rd_reg(REG_CTRL, r);       check("rst2_ctrl", r, 32'h0);
        rd_reg(REG_INTR_STAT, r);  check("rst2_intr", r, 32'h0);
        rd_reg(REG_STATUS, r);     check("rst2_status", r, stat(0, 0, 1'b0));
        rstn = 1'b1;
        exp_q.delete();
        idle(5);
        rd_reg(REG_STATUS, r);     check("post_rst_status", r, stat(0, 0, 1'b0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
